// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle for the shared ALU arbiter; ALU_ARB_ZERO_FLAG_EN adds resp_zero
interface alu_share_arbiter_if #(
   parameter int W   = 32,
   parameter int OPW = 3
);
   logic           req0_valid;
   logic           req0_ready;
   logic [OPW-1:0] req0_op;
   logic [W-1:0]   req0_a;
   logic [W-1:0]   req0_b;
   logic           req1_valid;
   logic           req1_ready;
   logic [OPW-1:0] req1_op;
   logic [W-1:0]   req1_a;
   logic [W-1:0]   req1_b;
   logic           resp_valid;
   logic           resp_ready;
   logic           resp_id;
   logic [W-1:0]   resp_r;
`ifdef ALU_ARB_ZERO_FLAG_EN
   logic           resp_zero;
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output resp_ready,
      input  req0_ready, req1_ready, resp_valid, resp_id, resp_r, resp_zero
   );
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  resp_ready,
      output req0_ready, req1_ready, resp_valid, resp_id, resp_r, resp_zero
   );
`else
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output resp_ready,
      input  req0_ready, req1_ready, resp_valid, resp_id, resp_r
   );
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  resp_ready,
      output req0_ready, req1_ready, resp_valid, resp_id, resp_r
   );
`endif
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU between two requesters; ALU_ARB_ZERO_FLAG_EN adds resp_zero
module alu_share_arbiter #(
   parameter int W   = 32,
   parameter int OPW = 3
) (
   input logic              clk,
   input logic              rst_n,
   alu_share_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   logic [1:0]     state;
   logic           prio;
   logic           gid;
   logic           lid;
   logic [OPW-1:0] lop;
   logic [W-1:0]   la;
   logic [W-1:0]   lb;
   logic [W-1:0]   alu_r;
   // pick a requester: a lone valid wins, a tie goes to prio; ready only in IDLE and out of reset
   always_comb begin
      gid = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
      bus.req0_ready = rst_n && state == IDLE && bus.req0_valid && !gid;
      bus.req1_ready = rst_n && state == IDLE && bus.req1_valid && gid;
   end
   // ALU on the operands latched at grant; reserved opcodes yield zero
   always_comb begin
      case (lop)
         3'd0:    alu_r = la & lb;
         3'd1:    alu_r = la | lb;
         3'd2:    alu_r = la + lb;
         3'd3:    alu_r = la - lb;
         3'd4:    alu_r = {{(W-1){1'b0}}, $signed(la) < $signed(lb)};
         3'd5:    alu_r = ~(la | lb);
         default: alu_r = '0;
      endcase
   end
   // IDLE grants and latches, EXEC registers the result, RESP holds it until consumed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         prio            <= 1'b0;
         lid             <= 1'b0;
         lop             <= '0;
         la              <= '0;
         lb              <= '0;
         bus.resp_valid  <= 1'b0;
         bus.resp_id     <= 1'b0;
         bus.resp_r      <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
         bus.resp_zero   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.req0_valid || bus.req1_valid) begin
               lid   <= gid;
               lop   <= gid ? bus.req1_op : bus.req0_op;
               la    <= gid ? bus.req1_a : bus.req0_a;
               lb    <= gid ? bus.req1_b : bus.req0_b;
               state <= EXEC;
            end
            EXEC: begin
               bus.resp_r     <= alu_r;
               bus.resp_id    <= lid;
`ifdef ALU_ARB_ZERO_FLAG_EN
               bus.resp_zero  <= alu_r == '0;
`endif
               bus.resp_valid <= 1'b1;
               state          <= RESP;
            end
            RESP: if (bus.resp_ready) begin
               bus.resp_valid <= 1'b0;
               prio           <= ~bus.resp_id;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
